// File: rtl/mesh_src_pkg.sv
// Shared packet field layout and border-terminal address helper for mesh_src_fifo.
package mesh_src_pkg;

  // Field positions are offsets below the packet MSB so they apply to any pkg_sz.
  localparam int unsigned NXT_MSB  = 0;
  localparam int unsigned ROW_MSB  = 8;
  localparam int unsigned COL_MSB  = 12;
  localparam int unsigned MODE_BIT = 16;
  localparam int unsigned FIELD_W  = 4;

  function automatic logic is_border_term(input logic [FIELD_W-1:0] row,
                                          input logic [FIELD_W-1:0] col,
                                          input int unsigned        rows,
                                          input int unsigned        cols);
    int unsigned r;
    int unsigned c;
    r = 32'(row);
    c = 32'(col);
    return (((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= cols)) ||
           (((c == 0) || (c == cols + 1)) && (r >= 1) && (r <= rows));
  endfunction

endpackage

// File: rtl/mesh_src_mem.sv
// Circular packet storage with wrapping read/write pointers and a registered
// show-ahead head register.
module mesh_src_mem
  import mesh_src_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [W-1:0] i_data,
  input  logic         i_next_empty,
  output logic [W-1:0] o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_next;
  logic [W-1:0]     r_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_rd_next = r_rd_ptr;
    if (i_rd) w_rd_next = ptr_inc(r_rd_ptr);
  end

  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      if (i_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      r_rd_ptr <= w_rd_next;
      // Next head is the slot being written this cycle only when that write lands
      // at the new read pointer (empty buffer, or last entry popped alongside a push).
      if (!i_next_empty) begin
        if (i_wr && (r_wr_ptr == w_rd_next)) r_head <= i_data;
        else                                 r_head <= r_mem[w_rd_next];
      end
    end
  end

  assign o_head = r_head;

endmodule

// File: rtl/mesh_src_fifo.sv
// Per-terminal mesh ingress FIFO with show-ahead pending/pop handshake, occupancy
// and saturating drop counter. Optional target check: MESH_SRC_ADDR_CHECK_EN.
module mesh_src_fifo
  import mesh_src_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMNS    = 4,
  parameter int unsigned pkg_sz     = 40,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [pkg_sz-1:0]                 data_in,
  output logic                              full,
  output logic                              pndng,
  output logic [pkg_sz-1:0]                 data_out,
  input  logic                              popin,
  output logic [$clog2(fifo_depth+1)-1:0]   count,
  output logic [15:0]                       drop_cnt
);

  localparam int unsigned CW = $clog2(fifo_depth + 1);

  logic          r_pndng;
  logic          r_full;
  logic [CW-1:0] r_count;
  logic [15:0]   r_drop_cnt;

  logic          w_pop;
  logic          w_addr_ok;
  logic          w_push_ok;
  logic          w_drop;
  logic [CW-1:0] w_count_next;

`ifdef MESH_SRC_ADDR_CHECK_EN
  assign w_addr_ok = is_border_term(data_in[pkg_sz-1-ROW_MSB -: FIELD_W],
                                    data_in[pkg_sz-1-COL_MSB -: FIELD_W],
                                    ROWS, COLUMNS);
`else
  assign w_addr_ok = 1'b1;
`endif

  assign w_pop     = popin & r_pndng;
  assign w_push_ok = push & (~r_full | w_pop) & w_addr_ok;
  assign w_drop    = push & ~w_push_ok;

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_pndng    <= 1'b0;
      r_full     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_count <= w_count_next;
      r_pndng <= (w_count_next != '0);
      r_full  <= (w_count_next == CW'(fifo_depth));
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  mesh_src_mem #(
    .DEPTH (fifo_depth),
    .W     (pkg_sz)
  ) u_mem (
    .clk          (clk),
    .reset        (reset),
    .i_wr         (w_push_ok),
    .i_rd         (w_pop),
    .i_data       (data_in),
    .i_next_empty (w_count_next == '0),
    .o_head       (data_out)
  );

  assign full     = r_full;
  assign pndng    = r_pndng;
  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_mesh_src_fifo.sv
// Randomized self-checking bench for mesh_src_fifo against a queue-based model.
module tb_mesh_src_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        push;
  logic [39:0] data_in;
  logic        full;
  logic        pndng;
  logic [39:0] data_out;
  logic        popin;
  logic [2:0]  count;
  logic [15:0] drop_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [39:0] mq[$];
  int unsigned m_drops;
  logic [39:0] m_head;

  mesh_src_fifo #(
    .ROWS       (4),
    .COLUMNS    (4),
    .pkg_sz     (40),
    .fifo_depth (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .data_in  (data_in),
    .full     (full),
    .pndng    (pndng),
    .data_out (data_out),
    .popin    (popin),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic addr_legal(input logic [39:0] d);
`ifdef MESH_SRC_ADDR_CHECK_EN
    int unsigned r;
    int unsigned c;
    r = 32'(d[31:28]);
    c = 32'(d[27:24]);
    return (((r == 0) || (r == 5)) && (c >= 1) && (c <= 4)) ||
           (((c == 0) || (c == 5)) && (r >= 1) && (r <= 4));
`else
    return (d[0] === d[0]);
`endif
  endfunction

  function automatic logic [39:0] mkpkt(input int unsigned row, input int unsigned col);
    logic [3:0]  r4;
    logic [3:0]  c4;
    logic [23:0] pay;
    r4  = 4'(row);
    c4  = 4'(col);
    pay = 24'($urandom);
    return {8'($urandom), r4, c4, pay};
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle 1ns past it.
  task automatic cycle(input logic p, input logic pp, input logic [39:0] d, input logic rst);
    logic do_pop;
    logic acc;
    push = p; popin = pp; data_in = d; reset = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_drops = 0;
      m_head  = '0;
    end else begin
      do_pop = pp && (mq.size() != 0);
      acc    = p && ((mq.size() < DEPTH) || do_pop) && addr_legal(d);
      if (do_pop) void'(mq.pop_front());
      if (acc) mq.push_back(d);
      else if (p && (m_drops < 65535)) m_drops++;
      if (mq.size() != 0) m_head = mq[0];
    end
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 40'h0000500000, 1'b1);
      checks++;
      if (pndng !== 1'b0 || count !== 3'd0 || drop_cnt !== 16'd0 || full !== 1'b0 || data_out !== 40'd0) begin
        errors++;
        $display("FAIL reset_state: pndng=%b count=%0d drop=%0d full=%b data=%h required 0/0/0/0/0",
                 pndng, count, drop_cnt, full, data_out);
      end
    end
    cycle(1'b1, 1'b0, 40'h0000500000, 1'b0);
    checks++;
    if (pndng !== (mq.size() != 0) || count !== 3'(mq.size()) || data_out !== m_head) begin
      errors++;
      $display("FAIL reset_release_push: pndng=%b count=%0d data=%h required %b/%0d/%h",
               pndng, count, data_out, mq.size() != 0, mq.size(), m_head);
    end
  endtask

  task automatic test_overflow();
    logic [39:0] pk;
    do_reset();
    for (int unsigned i = 1; i <= 5; i++) begin
      pk = mkpkt(0, (i <= 4) ? i : 1);
      cycle(1'b1, 1'b0, pk, 1'b0);
      checks++;
      if (count !== 3'(mq.size()) || full !== (mq.size() == DEPTH) || drop_cnt !== 16'(m_drops)) begin
        errors++;
        $display("FAIL overflow_push%0d: count=%0d full=%b drop=%0d required %0d/%b/%0d",
                 i, count, full, drop_cnt, mq.size(), mq.size() == DEPTH, m_drops);
      end
    end
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || drop_cnt !== 16'd1 || data_out !== mq[0]) begin
      errors++;
      $display("FAIL overflow_final: count=%0d full=%b drop=%0d head=%h required 4/1/1/%h",
               count, full, drop_cnt, data_out, mq[0]);
    end
  endtask

  task automatic test_full_push_pop();
    logic [39:0] pk;
    logic [39:0] exp_next;
    exp_next = mq[1];
    pk = mkpkt(0, 2);
    cycle(1'b1, 1'b1, pk, 1'b0);
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || drop_cnt !== 16'd1 || data_out !== exp_next) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d full=%b drop=%0d head=%h required 4/1/1/%h",
               count, full, drop_cnt, data_out, exp_next);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (count !== 3'(mq.size()) || pndng !== (mq.size() != 0) || data_out !== m_head) begin
        errors++;
        $display("FAIL drain%0d: count=%0d pndng=%b head=%h required %0d/%b/%h",
                 i, count, pndng, data_out, mq.size(), mq.size() != 0, m_head);
      end
    end
    checks++;
    if (pk !== m_head) begin
      errors++;
      $display("FAIL drain_last: last head=%h required %h", m_head, pk);
    end
  endtask

  task automatic test_empty_pop();
    logic [39:0] pk;
    do_reset();
    pk = mkpkt(5, 3);
    cycle(1'b1, 1'b0, pk, 1'b0);
    checks++;
    if (pndng !== 1'b1 || data_out !== pk) begin
      errors++;
      $display("FAIL single_push: pndng=%b head=%h required 1/%h", pndng, data_out, pk);
    end
    cycle(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (pndng !== 1'b0 || count !== 3'd0 || data_out !== pk) begin
      errors++;
      $display("FAIL single_pop: pndng=%b count=%0d head=%h required 0/0/%h", pndng, count, data_out, pk);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (pndng !== 1'b0 || count !== 3'd0 || full !== 1'b0 || drop_cnt !== 16'd0) begin
        errors++;
        $display("FAIL empty_pop%0d: pndng=%b count=%0d full=%b drop=%0d required 0/0/0/0",
                 i, pndng, count, full, drop_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    logic [39:0] seq [13];
    do_reset();
    for (int i = 0; i < 13; i++) seq[i] = mkpkt(0, 1 + (i % 4));
    cycle(1'b1, 1'b0, seq[0], 1'b0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (data_out !== seq[i] || pndng !== 1'b1 || count !== 3'd1) begin
        errors++;
        $display("FAIL wrap_seq%0d: head=%h pndng=%b count=%0d required %h/1/1",
                 i, data_out, pndng, count, seq[i]);
      end
      cycle(1'b1, 1'b1, seq[i+1], 1'b0);
    end
  endtask

  task automatic test_random();
    logic [39:0] pk;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) pk = mkpkt($urandom_range(0, 5), $urandom_range(0, 5));
      else                           pk = mkpkt(0, $urandom_range(1, 4));
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0 ? 0 : 1) | 1'(i[5]), pk, 1'b0);
      checks++;
      if (count !== 3'(mq.size()) || pndng !== (mq.size() != 0) || full !== (mq.size() == DEPTH) ||
          drop_cnt !== 16'(m_drops) || data_out !== m_head) begin
        errors++;
        $display("FAIL random%0d: count=%0d pndng=%b full=%b drop=%0d head=%h required %0d/%b/%b/%0d/%h",
                 i, count, pndng, full, drop_cnt, data_out,
                 mq.size(), mq.size() != 0, mq.size() == DEPTH, m_drops, m_head);
      end
    end
  endtask

`ifdef MESH_SRC_ADDR_CHECK_EN
  task automatic test_addr_check();
    logic [39:0] pk;
    do_reset();
    cycle(1'b1, 1'b0, mkpkt(2, 2), 1'b0);
    checks++;
    if (drop_cnt !== 16'd1 || count !== 3'd0 || pndng !== 1'b0) begin
      errors++;
      $display("FAIL addr_interior: drop=%0d count=%0d pndng=%b required 1/0/0", drop_cnt, count, pndng);
    end
    pk = mkpkt(5, 3);
    cycle(1'b1, 1'b0, pk, 1'b0);
    checks++;
    if (drop_cnt !== 16'd1 || count !== 3'd1 || data_out !== pk) begin
      errors++;
      $display("FAIL addr_border: drop=%0d count=%0d head=%h required 1/1/%h", drop_cnt, count, data_out, pk);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; push = 1'b0; popin = 1'b0; data_in = '0;
    mq.delete(); m_drops = 0; m_head = '0;
    test_reset();
    test_overflow();
    test_full_push_pop();
    test_empty_pop();
    test_wrap();
`ifdef MESH_SRC_ADDR_CHECK_EN
    test_addr_check();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_src_fifo.md
Name: mesh_src_fifo

Overview:
Per-terminal ingress buffer feeding one mesh terminal's input side (the mesh's pndng_i_in / data_out_i_in / popin signals). A host or agent pushes packets into it; the mesh pops them through a show-ahead pending/pop handshake. It tracks occupancy and counts rejected pushes. One instance per terminal, ROWS*2+COLUMNS*2 instances per mesh.

Parameters:
ROWS, 4, mesh rows; used for destination range check
COLUMNS, 4, mesh columns; used for destination range check
pkg_sz, 40, packet width in bits
fifo_depth, 4, entries; any value >= 2, not necessarily a power of two

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
push  in  1  host write strobe
data_in  in  pkg_sz  host packet
full  out  1  no free entry
pndng  out  1  head packet valid; drives mesh pndng_i_in
data_out  out  pkg_sz  head packet; drives mesh data_out_i_in
popin  in  1  mesh consumes head this cycle
count  out  $clog2(fifo_depth+1)  occupancy
drop_cnt  out  16  rejected pushes, saturating

Behaviour:
- Reset: all of pndng, full, count, drop_cnt = 0; data_out = 0; pointers = 0. Reset mid-traffic discards contents; the cycle after reset release behaves as empty.
- Packet fields: [pkg_sz-1:pkg_sz-8] nxt_jump, passed through untouched; [pkg_sz-9:pkg_sz-12] target row; [pkg_sz-13:pkg_sz-16] target column; [pkg_sz-17] mode; remainder is payload.
- Storage: circular buffer, rd/wr pointers wrap at fifo_depth-1 to 0, count register.
- Show-ahead: data_out = mem[rd_ptr] whenever pndng=1. data_out holds its value when pndng=0 and is don't-care to the mesh. pndng = (count != 0), registered.
- Push accepted iff push=1 and (full=0 or a pop occurs in the same cycle). Otherwise it is dropped and drop_cnt increments.
- Pop occurs iff popin=1 and pndng=1. popin with pndng=0 is ignored; no state change, no error.
- Push only: count+1. Pop only: count-1. Both at once: count unchanged, pointers both advance.
- Empty push has no bypass. pndng rises one cycle after the accepted push, so latency push to pndng = 1 cycle.
- After a pop, the next head is visible on data_out in the following cycle. If that pop emptied the buffer, pndng=0 in the following cycle.
- full = (count == fifo_depth), registered with count.
- drop_cnt saturates at 16'hFFFF.
- Order is strictly FIFO; no reordering or modification of packet bits.

Optional Feature:
Macro MESH_SRC_ADDR_CHECK_EN.
- Defined: a push is also rejected when its target is not a legal border terminal. Legal targets are row 0 or ROWS+1 with column 1..COLUMNS, or column 0 or COLUMNS+1 with row 1..ROWS. A rejected push is not stored and increments drop_cnt, even if the buffer has space.
- Not defined: no address check; only overflow causes drops.

Decomposition:
- Package mesh_src_pkg holds the field offset localparams (NXT_MSB, ROW_MSB, COL_MSB, MODE_BIT) and the function is_border_term(row, col, ROWS, COLUMNS).
- One natural sub-module: mesh_src_mem, the circular storage with pointers. Top level holds the handshake, counters and checks.

Test Plan:
- Reset with push=1, data_in=40'h0000500000 held -> pndng=0, count=0, drop_cnt=0 during reset. Push of 40'h0000500000 accepted on the first cycle after release; pndng=1 next cycle.
- Push 5 packets (rows 0, cols 1..4 and one extra) back-to-back with depth 4, popin=0 -> full=1 after the 4th, 5th push dropped, drop_cnt=1, count=4.
- Full buffer, push and popin in the same cycle -> count stays 4, old head leaves, new packet stored last, drop_cnt unchanged. Drain order matches push order.
- Single entry, popin=1 -> pndng=0 next cycle. Further popin=1 while empty leaves count=0, no underflow.
- 12 push/pop pairs with depth 4 (pointer wrap) -> data_out sequence equals the input sequence exactly.
- MESH_SRC_ADDR_CHECK_EN defined, push target (row 2, col 2) -> dropped, drop_cnt=1, count=0. Push target (row 5, col 3) -> accepted.
